// File: rtl/i2c_pkg.sv
// Shared I2C target definitions: FSM state encoding, bus constants and small helpers.
package i2c_pkg;

  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned RW_BIT = 0;

  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_RD  = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEVADDR,
    ST_DEVACK,
    ST_REGADDR,
    ST_REGACK,
    ST_WRDATA,
    ST_WRACK,
    ST_RDDATA,
    ST_RDACK,
    ST_IGNORE
  } state_e;

  function automatic logic is_read(input logic [BYTE_W-1:0] addr_byte);
    return addr_byte[RW_BIT] == I2C_RD;
  endfunction

endpackage

// File: rtl/i2c_bus_sync.sv
// Synchronizes scl/sda into clk and flags SCL edges plus START/STOP conditions.
module i2c_bus_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise_c,
  output logic o_scl_fall_c,
  output logic o_start_c,
  output logic o_stop_c
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  // Idle bus is high, so every stage resets to 1 to avoid a false edge out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= SYNC_STAGES'({r_scl_sync, i_scl});
      r_sda_sync <= SYNC_STAGES'({r_sda_sync, i_sda});
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl = r_scl_sync[SYNC_STAGES-1];
  assign w_sda = r_sda_sync[SYNC_STAGES-1];

  assign o_sda        = w_sda;
  assign o_scl_rise_c = w_scl & ~r_scl_d;
  assign o_scl_fall_c = ~w_scl & r_scl_d;
  assign o_start_c    = r_scl_d & w_scl & r_sda_d & ~w_sda;
  assign o_stop_c     = r_scl_d & w_scl & ~r_sda_d & w_sda;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte-addressed register port with an auto-incrementing pointer.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR    = 7'h68,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  inout  wire        sda,
  output logic [7:0] reg_addr,
  output logic       wr_en,
  output logic [7:0] wr_data,
  output logic       rd_req,
  input  logic [7:0] rd_data,
  output logic       busy
);

  state_e            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [BYTE_W-1:0] r_shift, w_shift_nxt;
  logic [BYTE_W-1:0] r_reg_addr, w_reg_addr_nxt;
  logic [BYTE_W-1:0] r_wr_data, w_wr_data_nxt;
  logic              r_rw, w_rw_nxt;
  logic              r_sda_oe, w_sda_oe_nxt;
  logic              r_wr_en, w_wr_en_nxt;
  logic              r_rd_req, w_rd_req_nxt;
  logic              r_busy, w_busy_nxt;

  logic w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic w_byte_done, w_addr_match, w_shift_state;

  i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_scl        (scl),
    .i_sda        (sda),
    .o_sda        (w_sda),
    .o_scl_rise_c (w_scl_rise),
    .o_scl_fall_c (w_scl_fall),
    .o_start_c    (w_start),
    .o_stop_c     (w_stop)
  );

  assign w_byte_done   = w_scl_fall && (r_cnt == CNT_W'(BYTE_W));
  assign w_addr_match  = (r_shift[BYTE_W-1:RW_BIT+1] == DEV_ADDR);
  assign w_shift_state = (r_state == ST_DEVADDR) || (r_state == ST_REGADDR) ||
                         (r_state == ST_WRDATA)  || (r_state == ST_RDDATA);

  // Reset gates the drive combinationally so a mid-ACK reset frees the bus at once
  assign sda      = (r_sda_oe && rst_n) ? 1'b0 : 1'bz;
  assign reg_addr = r_reg_addr;
  assign wr_en    = r_wr_en;
  assign wr_data  = r_wr_data;
  assign rd_req   = r_rd_req;
  assign busy     = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_cnt      <= '0;
      r_shift    <= '0;
      r_reg_addr <= '0;
      r_wr_data  <= '0;
      r_rw       <= 1'b0;
      r_sda_oe   <= 1'b0;
      r_wr_en    <= 1'b0;
      r_rd_req   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_reg_addr <= w_reg_addr_nxt;
      r_wr_data  <= w_wr_data_nxt;
      r_rw       <= w_rw_nxt;
      r_sda_oe   <= w_sda_oe_nxt;
      r_wr_en    <= w_wr_en_nxt;
      r_rd_req   <= w_rd_req_nxt;
      r_busy     <= w_busy_nxt;
    end
  end

  // Byte-level protocol sequencing; START/STOP pre-empt everything
  always_comb begin
    w_state_nxt = r_state;
    if (w_start) begin
      w_state_nxt = ST_DEVADDR;
    end else if (w_stop) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_DEVADDR: if (w_byte_done) w_state_nxt = w_addr_match ? ST_DEVACK : ST_IGNORE;
        ST_DEVACK:  if (w_scl_fall)  w_state_nxt = r_rw ? ST_RDDATA : ST_REGADDR;
        ST_REGADDR: if (w_byte_done) w_state_nxt = ST_REGACK;
        ST_REGACK:  if (w_scl_fall)  w_state_nxt = ST_WRDATA;
        ST_WRDATA:  if (w_byte_done) w_state_nxt = ST_WRACK;
        ST_WRACK:   if (w_scl_fall)  w_state_nxt = ST_WRDATA;
        ST_RDDATA:  if (w_byte_done) w_state_nxt = ST_RDACK;
        ST_RDACK: begin
          if (w_scl_rise && (w_sda != I2C_ACK)) w_state_nxt = ST_IGNORE;
          else if (w_scl_fall)                  w_state_nxt = ST_RDDATA;
        end
        default: w_state_nxt = r_state;
      endcase
    end
  end

  // Datapath: the shift register serves both directions, read data leaves via bit 7
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_shift_nxt    = r_rd_req ? rd_data : r_shift;
    w_rw_nxt       = r_rw;
    w_sda_oe_nxt   = r_sda_oe;
    w_reg_addr_nxt = r_reg_addr;
    w_wr_en_nxt    = 1'b0;
    w_wr_data_nxt  = r_wr_data;
    w_rd_req_nxt   = 1'b0;
    w_busy_nxt     = r_busy;
    if (w_start || w_stop) begin
      w_cnt_nxt    = '0;
      w_sda_oe_nxt = 1'b0;
      if (w_stop) w_busy_nxt = 1'b0;
    end else begin
      if (w_scl_rise && w_shift_state) begin
        w_shift_nxt = {r_shift[BYTE_W-2:0], w_sda};
        w_cnt_nxt   = r_cnt + CNT_W'(1);
      end
      case (r_state)
        ST_DEVADDR: begin
          if (w_byte_done && w_addr_match) begin
            w_sda_oe_nxt = 1'b1;
            w_busy_nxt   = 1'b1;
            w_rw_nxt     = is_read(r_shift);
          end
        end
        ST_DEVACK: begin
          // Fetch during the ACK high phase so the MSB is ready at the falling edge
          if (w_scl_rise && r_rw) w_rd_req_nxt = 1'b1;
          if (w_scl_fall) begin
            w_cnt_nxt    = '0;
            w_sda_oe_nxt = r_rw && !r_shift[BYTE_W-1];
          end
        end
        ST_REGADDR: begin
          if (w_byte_done) begin
            w_reg_addr_nxt = r_shift;
            w_sda_oe_nxt   = 1'b1;
          end
        end
        ST_REGACK: begin
          if (w_scl_fall) begin
            w_cnt_nxt    = '0;
            w_sda_oe_nxt = 1'b0;
          end
        end
        ST_WRDATA: begin
          if (w_byte_done) begin
            w_wr_en_nxt   = 1'b1;
            w_wr_data_nxt = r_shift;
            w_sda_oe_nxt  = 1'b1;
          end
        end
        ST_WRACK: begin
          if (w_scl_fall) begin
            w_cnt_nxt      = '0;
            w_sda_oe_nxt   = 1'b0;
            w_reg_addr_nxt = r_reg_addr + 8'd1;
          end
        end
        ST_RDDATA: begin
          if (w_scl_fall) w_sda_oe_nxt = !w_byte_done && !r_shift[BYTE_W-1];
        end
        ST_RDACK: begin
          if (w_scl_rise && (w_sda == I2C_ACK)) begin
            w_reg_addr_nxt = r_reg_addr + 8'd1;
            w_rd_req_nxt   = 1'b1;
          end
          if (w_scl_fall) begin
            w_cnt_nxt    = '0;
            w_sda_oe_nxt = !r_shift[BYTE_W-1];
          end
        end
        default: w_sda_oe_nxt = r_sda_oe;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench: bit-banged initiator, transaction-level register model, per-cycle output compare.
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam int unsigned Q = 5;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       scl;
  logic       m_low;
  wire        sda;
  logic [7:0] reg_addr, wr_data, rd_data;
  logic       wr_en, rd_req, busy;

  pullup (sda);
  assign sda = m_low ? 1'b0 : 1'bz;

  always #5 clk = ~clk;

  i2c_target_regs #(.DEV_ADDR(7'h68), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .scl      (scl),
    .sda      (sda),
    .reg_addr (reg_addr),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_req   (rd_req),
    .rd_data  (rd_data),
    .busy     (busy)
  );

  logic [7:0] mem [0:255];
  assign rd_data = mem[reg_addr];

  int          n_total = 0;
  int          n_bad   = 0;
  logic [7:0]  m_addr;
  logic        m_busy;
  logic [15:0] exp_wr_q[$];
  logic [7:0]  exp_rd_q[$];
  logic        chk_nodrive = 1'b0;
  logic        chk_nobusy  = 1'b0;

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic xfer_bit(input logic b, output logic got);
    m_low = !b;
    wait_q();
    scl = 1'b1;
    wait_q();
    got = sda;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_start();
    m_low = 1'b0;
    wait_q();
    scl = 1'b1;
    wait_q();
    m_low = 1'b1;
    wait_q();
    scl = 1'b0;
    wait_q();
  endtask

  task automatic i2c_stop();
    m_low = 1'b1;
    wait_q();
    scl = 1'b1;
    wait_q();
    m_low = 1'b0;
    wait_q();
    wait_q();
    m_busy = 1'b0;
    check("busy_after_stop", 16'(busy), 16'(m_busy));
    check("sda_after_stop", 16'(sda), 16'(1'b1));
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string name);
    logic got;
    for (int i = 7; i >= 0; i--) xfer_bit(b[i], got);
    xfer_bit(1'b1, got);
    check(name, 16'(got), 16'(exp_ack ? 1'b0 : 1'b1));
  endtask

  // Model: a matching address is ACKed; a matching read fetches at the pointer immediately
  task automatic dev_phase(input logic [7:0] b);
    logic matched;
    matched = (b[7:1] == 7'h68);
    if (matched) m_busy = 1'b1;
    if (matched && b[0]) exp_rd_q.push_back(m_addr);
    send_byte(b, matched, "dev_ack");
    check("busy_after_dev", 16'(busy), 16'(m_busy));
  endtask

  task automatic reg_phase(input logic [7:0] b);
    send_byte(b, 1'b1, "reg_ack");
    m_addr = b;
  endtask

  task automatic data_phase(input logic [7:0] b);
    exp_wr_q.push_back({m_addr, b});
    send_byte(b, 1'b1, "wr_ack");
    m_addr = m_addr + 8'd1;
  endtask

  task automatic read_phase(input logic ack, output logic [7:0] val);
    logic got;
    logic [7:0] exp;
    exp = mem[m_addr];
    val = '0;
    for (int i = 0; i < 8; i++) begin
      xfer_bit(1'b1, got);
      val = {val[6:0], got};
    end
    check("rd_byte_model", 16'(val), 16'(exp));
    if (ack) begin
      m_addr = m_addr + 8'd1;
      exp_rd_q.push_back(m_addr);
    end
    xfer_bit(!ack, got);
  endtask

  // Output compare, sampled 1 time unit after each rising edge
  always begin
    logic [15:0] ew;
    logic [7:0]  er;
    @(posedge clk);
    #1;
    if (rst_n) begin
      if (wr_en) begin
        check("wr_expected", 16'(exp_wr_q.size() != 0), 16'(1'b1));
        if (exp_wr_q.size() != 0) begin
          ew = exp_wr_q.pop_front();
          check("wr_addr", 16'(reg_addr), 16'(ew[15:8]));
          check("wr_data", 16'(wr_data), 16'(ew[7:0]));
        end
      end
      if (rd_req) begin
        check("rd_expected", 16'(exp_rd_q.size() != 0), 16'(1'b1));
        if (exp_rd_q.size() != 0) begin
          er = exp_rd_q.pop_front();
          check("rd_addr", 16'(reg_addr), 16'(er));
        end
      end
      if (chk_nodrive && !m_low) check("sda_released", 16'(sda), 16'(1'b1));
      if (chk_nobusy) check("busy_low", 16'(busy), 16'(1'b0));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] rv;
    logic       got;
    rst_n  = 1'b0;
    scl    = 1'b1;
    m_low  = 1'b0;
    m_addr = 8'h00;
    m_busy = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    mem[8'h3B] = 8'h12;
    mem[8'h3C] = 8'h34;
    mem[8'h40] = 8'hA5;
    repeat (4) @(negedge clk);
    check("rst_reg_addr", 16'(reg_addr), 16'h00);
    check("rst_wr_en", 16'(wr_en), 16'h0);
    check("rst_wr_data", 16'(wr_data), 16'h00);
    check("rst_rd_req", 16'(rd_req), 16'h0);
    check("rst_busy", 16'(busy), 16'h0);
    check("rst_sda", 16'(sda), 16'h1);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Single register write
    i2c_start();
    dev_phase(8'hD0);
    reg_phase(8'h6B);
    data_phase(8'h00);
    i2c_stop();
    check("w1_reg_addr_lit", 16'(reg_addr), 16'h6C);
    check("w1_reg_addr", 16'(reg_addr), 16'(m_addr));

    // Pointer write, repeated START, two-byte read
    i2c_start();
    dev_phase(8'hD0);
    reg_phase(8'h3B);
    i2c_start();
    dev_phase(8'hD1);
    read_phase(1'b1, rv);
    check("rd0_lit", 16'(rv), 16'h12);
    read_phase(1'b0, rv);
    check("rd1_lit", 16'(rv), 16'h34);
    check("state_ignore", 16'(dut.r_state), 16'(ST_IGNORE));
    chk_nodrive = 1'b1;
    send_byte(8'hFF, 1'b0, "ignore_nack");
    chk_nodrive = 1'b0;
    i2c_stop();
    check("r1_reg_addr_lit", 16'(reg_addr), 16'h3C);
    check("r1_reg_addr", 16'(reg_addr), 16'(m_addr));

    // Foreign address: bus untouched
    chk_nodrive = 1'b1;
    chk_nobusy  = 1'b1;
    i2c_start();
    dev_phase(8'hA0);
    send_byte(8'h55, 1'b0, "miss_data_nack");
    i2c_stop();
    chk_nodrive = 1'b0;
    chk_nobusy  = 1'b0;
    check("miss_reg_addr", 16'(reg_addr), 16'(m_addr));

    // Pointer wrap across 0xFF
    i2c_start();
    dev_phase(8'hD0);
    reg_phase(8'hFF);
    data_phase(8'h11);
    data_phase(8'h22);
    i2c_stop();
    check("wrap_reg_addr_lit", 16'(reg_addr), 16'h01);
    check("wrap_wr_data_lit", 16'(wr_data), 16'h22);

    // STOP four bits into a data byte
    i2c_start();
    dev_phase(8'hD0);
    reg_phase(8'h40);
    xfer_bit(1'b1, got);
    xfer_bit(1'b0, got);
    xfer_bit(1'b1, got);
    xfer_bit(1'b0, got);
    i2c_stop();
    check("partial_reg_addr_lit", 16'(reg_addr), 16'h40);
    check("partial_state_idle", 16'(dut.r_state), 16'(ST_IDLE));

    // Read from the persisting pointer with no pointer write
    i2c_start();
    dev_phase(8'hD1);
    read_phase(1'b0, rv);
    check("rd_persist_lit", 16'(rv), 16'hA5);
    i2c_stop();
    check("rd_persist_reg_addr", 16'(reg_addr), 16'h40);

    // Reset while the target drives ACK
    i2c_start();
    for (int i = 7; i >= 0; i--) begin
      rv = 8'hD0;
      xfer_bit(rv[i], got);
    end
    m_low = 1'b0;
    wait_q();
    check("ack_driven_pre_rst", 16'(sda), 16'h0);
    check("busy_pre_rst", 16'(busy), 16'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_mid_sda", 16'(sda), 16'h1);
    check("rst_mid_reg_addr", 16'(reg_addr), 16'h00);
    check("rst_mid_wr_data", 16'(wr_data), 16'h00);
    check("rst_mid_wr_en", 16'(wr_en), 16'h0);
    check("rst_mid_rd_req", 16'(rd_req), 16'h0);
    check("rst_mid_busy", 16'(busy), 16'h0);
    check("rst_mid_state", 16'(dut.r_state), 16'(ST_IDLE));
    scl = 1'b1;
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    m_addr = 8'h00;
    m_busy = 1'b0;
    repeat (4) @(negedge clk);

    check("wr_q_drained", 16'(exp_wr_q.size()), 16'h0);
    check("rd_q_drained", 16'(exp_rd_q.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
